// File: rtl/fft_sched_pkg.sv
// Package for the FFT ping-pong memory scheduler: FSM state and write-owner
// enums, plus helpers that derive the stage count and stage index width.
`include "fft_defs.vh"

package fft_sched_pkg;

  localparam int ADDR_W = `ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UNLOAD = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_LOADER = 2'd1,
    OWN_FFT    = 2'd2
  } owner_e;

  // Radix-2 transform of fft_size points needs log2(fft_size) stages.
  function automatic int num_stages_f(input int fft_size);
    return $clog2(fft_size);
  endfunction

  // Width able to hold 0..NUM_STAGES.
  function automatic int stg_w_f(input int fft_size);
    return $clog2($clog2(fft_size) + 1);
  endfunction

endpackage

// File: rtl/fft_defs.vh
// Shared defines for the FFT memory scheduler slice.
// ADDR_WIDTH covers the largest supported transform (65536 points).
`ifndef FFT_DEFS_VH
`define FFT_DEFS_VH
`define ADDR_WIDTH 16
`endif

// File: rtl/fft_wport_mux.sv
// Combinational write-port multiplexer in front of the ping-pong memory.
// The loader drives port a only; the FFT core drives both ports; with no
// owner everything is zero. force_off blocks both write enables outright.
module fft_wport_mux
  import fft_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  owner_e                owner,
  input  logic                  force_off,
  input  logic [ADDR_W-1:0]     ld_waddr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  input  logic                  ld_we,
  input  logic [ADDR_W-1:0]     fft_waddra,
  input  logic [ADDR_W-1:0]     fft_waddrb,
  input  logic [DATA_WIDTH-1:0] fft_wdataa,
  input  logic [DATA_WIDTH-1:0] fft_wdatab,
  input  logic                  fft_wea,
  input  logic                  fft_web,
  output logic [ADDR_W-1:0]     mem_waddra,
  output logic [ADDR_W-1:0]     mem_waddrb,
  output logic [DATA_WIDTH-1:0] mem_wdataa,
  output logic [DATA_WIDTH-1:0] mem_wdatab,
  output logic                  mem_wea,
  output logic                  mem_web
);

  logic sel_wea;
  logic sel_web;

  // Route the current owner's port onto the memory; non-owners see nothing.
  always_comb begin
    mem_waddra = '0;
    mem_waddrb = '0;
    mem_wdataa = '0;
    mem_wdatab = '0;
    sel_wea    = 1'b0;
    sel_web    = 1'b0;
    case (owner)
      OWN_LOADER: begin
        mem_waddra = ld_waddr;
        mem_wdataa = ld_wdata;
        sel_wea    = ld_we;
      end
      OWN_FFT: begin
        mem_waddra = fft_waddra;
        mem_waddrb = fft_waddrb;
        mem_wdataa = fft_wdataa;
        mem_wdatab = fft_wdatab;
        sel_wea    = fft_wea;
        sel_web    = fft_web;
      end
      OWN_NONE: begin
        sel_wea = 1'b0;
        sel_web = 1'b0;
      end
      default: begin
        sel_wea = 1'b0;
        sel_web = 1'b0;
      end
    endcase
  end

  assign mem_wea = force_off ? 1'b0 : sel_wea;
  assign mem_web = force_off ? 1'b0 : sel_web;

endmodule

// File: rtl/fft_mem_sched.sv
// FFT ping-pong memory scheduler: sequences load, per-stage FFT runs and
// unload, toggles the write bank after every fill, and grants write access
// to the current owner through fft_wport_mux.
// Optional stage watchdog: define FFT_MEM_SCHED_TIMEOUT_EN.
module fft_mem_sched
  import fft_sched_pkg::*;
#(
  parameter int  FFT_SIZE       = 4096,
  parameter int  DATA_WIDTH     = 64,
  parameter int  TIMEOUT_CYCLES = 65535,
  localparam int NUM_STAGES     = num_stages_f(FFT_SIZE),
  localparam int STG_W          = stg_w_f(FFT_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  ld_done,
  input  logic [ADDR_W-1:0]     ld_waddr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  input  logic                  ld_we,
  input  logic [ADDR_W-1:0]     fft_waddra,
  input  logic [ADDR_W-1:0]     fft_waddrb,
  input  logic [DATA_WIDTH-1:0] fft_wdataa,
  input  logic [DATA_WIDTH-1:0] fft_wdatab,
  input  logic                  fft_wea,
  input  logic                  fft_web,
  input  logic                  stage_done,
  input  logic                  unld_done,
  output logic [ADDR_W-1:0]     mem_waddra,
  output logic [ADDR_W-1:0]     mem_waddrb,
  output logic [DATA_WIDTH-1:0] mem_wdataa,
  output logic [DATA_WIDTH-1:0] mem_wdatab,
  output logic                  mem_wea,
  output logic                  mem_web,
  output logic                  wmem_id,
  output logic                  rmem_id,
  output logic                  stage_start,
  output logic [STG_W-1:0]      stage_idx,
  output logic                  unld_start,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  err
);

  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_STAGES - 1);

  // Elaboration-time guard on the configuration range.
  if ((FFT_SIZE < 16) || (FFT_SIZE > 65536) || ((FFT_SIZE & (FFT_SIZE - 1)) != 0)) begin : g_bad_size
    $error("fft_mem_sched: FFT_SIZE must be a power of two in 16..65536");
  end
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_tmo
    $error("fft_mem_sched: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_e             state_r;
  state_e             next_state;
  owner_e             owner;
  logic               wmem_id_r;
  logic [STG_W-1:0]   stage_idx_r;
  logic               stage_start_r;
  logic               unld_start_r;
  logic               frame_done_r;
  logic               busy_r;
  logic               start_accept;
  logic               ld_accept;
  logic               stage_accept;
  logic               last_stage;
  logic               unld_accept;
  logic               tmo_fire;
  logic               tmo_hit;

`ifdef FFT_MEM_SCHED_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_r;
  logic        err_r;

  assign tmo_hit = (state_r == ST_WAIT) && (tmo_cnt_r == TMO_LAST);

  // Watchdog: restart on WAIT entry, count each WAIT cycle; sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= 16'd0;
      err_r     <= 1'b0;
    end else begin
      if ((state_r != ST_WAIT) && (next_state == ST_WAIT)) begin
        tmo_cnt_r <= 16'd0;
      end else if (state_r == ST_WAIT) begin
        tmo_cnt_r <= tmo_cnt_r + 16'd1;
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
      if (start_accept) begin
        err_r <= 1'b0;
      end else if (tmo_fire) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign err = err_r;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // Next-state decode; events outside their own state are simply not decoded.
  always_comb begin
    next_state   = state_r;
    start_accept = 1'b0;
    ld_accept    = 1'b0;
    stage_accept = 1'b0;
    last_stage   = 1'b0;
    unld_accept  = 1'b0;
    tmo_fire     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          next_state   = ST_LOAD;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (ld_done) begin
          ld_accept  = 1'b1;
          next_state = ST_RUN;
        end else begin
          next_state = ST_LOAD;
        end
      end
      ST_RUN: begin
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (stage_done) begin
          stage_accept = 1'b1;
          if (stage_idx_r == LAST_STAGE) begin
            last_stage = 1'b1;
            next_state = ST_UNLOAD;
          end else begin
            next_state = ST_RUN;
          end
        end else if (tmo_hit) begin
          tmo_fire   = 1'b1;
          next_state = ST_IDLE;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_UNLOAD: begin
        if (unld_done) begin
          unld_accept = 1'b1;
          next_state  = ST_IDLE;
        end else begin
          next_state = ST_UNLOAD;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state;
    end
  end

  // Bank toggle after each completed fill, and stage index tracking.
  // wmem_id is deliberately kept across frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      wmem_id_r   <= 1'b0;
      stage_idx_r <= '0;
    end else begin
      if (ld_accept || stage_accept) begin
        wmem_id_r <= ~wmem_id_r;
      end else begin
        wmem_id_r <= wmem_id_r;
      end
      if (start_accept || unld_accept || tmo_fire) begin
        stage_idx_r <= '0;
      end else if (stage_accept && !last_stage) begin
        stage_idx_r <= stage_idx_r + STG_W'(1);
      end else begin
        stage_idx_r <= stage_idx_r;
      end
    end
  end

  // Registered pulses and busy flag, aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_start_r <= 1'b0;
      unld_start_r  <= 1'b0;
      frame_done_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      stage_start_r <= (next_state == ST_RUN);
      unld_start_r  <= (state_r != ST_UNLOAD) && (next_state == ST_UNLOAD);
      frame_done_r  <= unld_accept;
      busy_r        <= (next_state != ST_IDLE);
    end
  end

  // Write ownership follows the current state.
  always_comb begin
    owner = OWN_NONE;
    case (state_r)
      ST_LOAD: owner = OWN_LOADER;
      ST_RUN:  owner = OWN_FFT;
      ST_WAIT: owner = OWN_FFT;
      default: owner = OWN_NONE;
    endcase
  end

  fft_wport_mux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wport_mux (
    .owner      (owner),
    .force_off  (rst),
    .ld_waddr   (ld_waddr),
    .ld_wdata   (ld_wdata),
    .ld_we      (ld_we),
    .fft_waddra (fft_waddra),
    .fft_waddrb (fft_waddrb),
    .fft_wdataa (fft_wdataa),
    .fft_wdatab (fft_wdatab),
    .fft_wea    (fft_wea),
    .fft_web    (fft_web),
    .mem_waddra (mem_waddra),
    .mem_waddrb (mem_waddrb),
    .mem_wdataa (mem_wdataa),
    .mem_wdatab (mem_wdatab),
    .mem_wea    (mem_wea),
    .mem_web    (mem_web)
  );

  assign wmem_id     = wmem_id_r;
  assign rmem_id     = ~wmem_id_r;
  assign stage_idx   = stage_idx_r;
  assign stage_start = stage_start_r;
  assign unld_start  = unld_start_r;
  assign frame_done  = frame_done_r;
  assign busy        = busy_r;

endmodule
